// File: rtl/tv80_busctl_pkg.sv
// Shared encodings for the TV80 bus-cycle controller: wait FSM states,
// bus-cycle classes and wait-count register selectors.
package tv80_busctl_pkg;

   typedef enum logic [1:0] {
      WS_IDLE   = 2'd0,
      WS_INSERT = 2'd1,
      WS_EXT    = 2'd2
   } ws_state_t;

   typedef enum logic [2:0] {
      CYC_NONE = 3'd0,
      CYC_M1   = 3'd1,
      CYC_INTA = 3'd2,
      CYC_MEM  = 3'd3,
      CYC_IO   = 3'd4
   } cyc_class_t;

   localparam logic [1:0] CFG_SEL_M1  = 2'd0;
   localparam logic [1:0] CFG_SEL_MEM = 2'd1;
   localparam logic [1:0] CFG_SEL_IO  = 2'd2;

   // Classify the core's current machine cycle from its status lines.
   function automatic cyc_class_t decode_class(
      input logic m1_cycle,
      input logic intcycle_n,
      input logic no_read,
      input logic write,
      input logic iorq
   );
      cyc_class_t cls;
      if (m1_cycle) begin
         cls = intcycle_n ? CYC_M1 : CYC_INTA;
      end else if (write | ~no_read) begin
         cls = iorq ? CYC_IO : CYC_MEM;
      end else begin
         cls = CYC_NONE;
      end
      return cls;
   endfunction

endpackage

// File: rtl/tv80_waitgen.sv
// Programmable wait-state generator: per-class wait counts, the insert/extend
// FSM and the combined wait returned to the core.
module tv80_waitgen
   import tv80_busctl_pkg::*;
#(
   parameter int unsigned WS_W   = 3,
   parameter int unsigned M1_WS  = 0,
   parameter int unsigned MEM_WS = 0,
   parameter int unsigned IO_WS  = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            m1_cycle,
   input  logic            intcycle_n,
   input  logic            no_read,
   input  logic            write,
   input  logic            iorq,
   input  logic            t1,
   input  logic            t2,
   input  logic            ext_wait_n,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_sel,
   input  logic [WS_W-1:0] cfg_data,
   output logic            core_wait_n
);

   localparam logic [WS_W-1:0] WS_ZERO = {WS_W{1'b0}};
   localparam logic [WS_W-1:0] WS_ONE  = WS_W'(1'b1);

   ws_state_t       state_r;
   ws_state_t       state_nx_s;
   logic [WS_W-1:0] ws_cnt_r;
   logic [WS_W-1:0] ws_cnt_nx_s;
   logic [WS_W-1:0] m1_ws_r;
   logic [WS_W-1:0] mem_ws_r;
   logic [WS_W-1:0] io_ws_r;
   logic [WS_W-1:0] cls_cnt_s;
   cyc_class_t      cls_s;

   // Class decode and selection of the count loaded at T1.
   always_comb begin
      cls_s = decode_class(m1_cycle, intcycle_n, no_read, write, iorq);
      case (cls_s)
         CYC_M1:           cls_cnt_s = m1_ws_r;
         CYC_INTA, CYC_IO: cls_cnt_s = io_ws_r;
         CYC_MEM:          cls_cnt_s = mem_ws_r;
         default:          cls_cnt_s = WS_ZERO;
      endcase
   end

   // Runtime wait counts; a write mid-cycle only matters at the next T1 load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m1_ws_r  <= WS_W'(M1_WS);
         mem_ws_r <= WS_W'(MEM_WS);
         io_ws_r  <= WS_W'(IO_WS);
      end else if (cfg_we) begin
         case (cfg_sel)
            CFG_SEL_M1:  m1_ws_r  <= cfg_data;
            CFG_SEL_MEM: mem_ws_r <= cfg_data;
            CFG_SEL_IO:  io_ws_r  <= cfg_data;
            default:     ;
         endcase
      end
   end

   // Wait FSM state and remaining-count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= WS_IDLE;
         ws_cnt_r <= WS_ZERO;
      end else begin
         state_r  <= state_nx_s;
         ws_cnt_r <= ws_cnt_nx_s;
      end
   end

   // Wait FSM next state: load at T1, count down inserted T2s, then defer to ext_wait_n.
   always_comb begin
      state_nx_s  = state_r;
      ws_cnt_nx_s = ws_cnt_r;
      case (state_r)
         WS_IDLE: begin
            if (t1) begin
               ws_cnt_nx_s = cls_cnt_s;
               if (cls_s == CYC_NONE) begin
                  state_nx_s = WS_IDLE;
               end else if (cls_cnt_s != WS_ZERO) begin
                  state_nx_s = WS_INSERT;
               end else begin
                  state_nx_s = WS_EXT;
               end
            end else begin
               state_nx_s = WS_IDLE;
            end
         end
         WS_INSERT: begin
            if (t2) begin
               ws_cnt_nx_s = ws_cnt_r - WS_ONE;
               state_nx_s  = (ws_cnt_r == WS_ONE) ? WS_EXT : WS_INSERT;
            end else begin
               state_nx_s = WS_INSERT;
            end
         end
         WS_EXT: begin
            if (t2) begin
               state_nx_s = WS_EXT;
            end else begin
               state_nx_s = WS_IDLE;
            end
         end
         default: begin
            state_nx_s  = WS_IDLE;
            ws_cnt_nx_s = WS_ZERO;
         end
      endcase
   end

   assign core_wait_n = ~((state_r == WS_INSERT) & t2) & ext_wait_n;

endmodule

// File: rtl/tv80_busctl.sv
// TV80 bus-cycle controller: negedge-registered bus strobes, read-data capture
// and the built-in wait-state generator.
module tv80_busctl
   import tv80_busctl_pkg::*;
#(
   parameter int unsigned T2WRITE = 0,
   parameter int unsigned WS_W    = 3,
   parameter int unsigned M1_WS   = 0,
   parameter int unsigned MEM_WS  = 0,
   parameter int unsigned IO_WS   = 1,
   parameter int unsigned DW      = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [6:0]      mcycle,
   input  logic [6:0]      tstate,
   input  logic            intcycle_n,
   input  logic            no_read,
   input  logic            write,
   input  logic            iorq,
   input  logic            busak_n,
   input  logic            ext_wait_n,
   output logic            core_wait_n,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_sel,
   input  logic [WS_W-1:0] cfg_data,
   input  logic [DW-1:0]   di,
   output logic [DW-1:0]   di_reg,
   output logic            mreq_n,
   output logic            iorq_n,
   output logic            rd_n,
   output logic            wr_n
);

   cyc_class_t cls_s;
   logic       t12_s;
   logic       wr_win_s;
   logic       rd_nx_s;
   logic       wr_nx_s;
   logic       mreq_nx_s;
   logic       iorq_nx_s;
   logic       unused_s;

   assign unused_s = ^{mcycle[6:1], tstate[6:3], tstate[0]};

   tv80_waitgen #(
      .WS_W   (WS_W),
      .M1_WS  (M1_WS),
      .MEM_WS (MEM_WS),
      .IO_WS  (IO_WS)
   ) u_waitgen (
      .clk         (clk),
      .reset_n     (reset_n),
      .m1_cycle    (mcycle[0]),
      .intcycle_n  (intcycle_n),
      .no_read     (no_read),
      .write       (write),
      .iorq        (iorq),
      .t1          (tstate[1]),
      .t2          (tstate[2]),
      .ext_wait_n  (ext_wait_n),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_data    (cfg_data),
      .core_wait_n (core_wait_n)
   );

   assign t12_s = tstate[1] | tstate[2];

   // T2WRITE=1 opens the write strobe at T1 and holds it through waits; otherwise only the last T2.
   assign wr_win_s = (T2WRITE != 32'd0) ? (tstate[1] | (tstate[2] & ~core_wait_n))
                                        : (tstate[2] & core_wait_n);

   // Strobe next state from the current cycle class and T-state.
   always_comb begin
      rd_nx_s   = 1'b1;
      wr_nx_s   = 1'b1;
      mreq_nx_s = 1'b1;
      iorq_nx_s = 1'b1;
      cls_s     = decode_class(mcycle[0], intcycle_n, no_read, write, iorq);
      if (busak_n) begin
         case (cls_s)
            CYC_M1, CYC_INTA: begin
               if (t12_s) begin
                  rd_nx_s   = ~intcycle_n;
                  mreq_nx_s = ~intcycle_n;
                  iorq_nx_s = intcycle_n;
               end else begin
                  rd_nx_s = 1'b1;
               end
            end
            CYC_MEM, CYC_IO: begin
               if (write) begin
                  if (wr_win_s) begin
                     wr_nx_s   = 1'b0;
                     iorq_nx_s = ~iorq;
                     mreq_nx_s = iorq;
                  end else begin
                     wr_nx_s = 1'b1;
                  end
               end else if (t12_s) begin
                  rd_nx_s   = 1'b0;
                  iorq_nx_s = ~iorq;
                  mreq_nx_s = iorq;
               end else begin
                  rd_nx_s = 1'b1;
               end
            end
            default: begin
               rd_nx_s = 1'b1;
            end
         endcase
      end else begin
         rd_nx_s = 1'b1;
      end
   end

   // Falling-edge strobe registers; reset releases the bus without waiting for a clock.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_n   <= 1'b1;
         wr_n   <= 1'b1;
         mreq_n <= 1'b1;
         iorq_n <= 1'b1;
      end else begin
         rd_n   <= rd_nx_s;
         wr_n   <= wr_nx_s;
         mreq_n <= mreq_nx_s;
         iorq_n <= iorq_nx_s;
      end
   end

   // Read data is captured on the final T2, when no wait is pending.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         di_reg <= {DW{1'b0}};
      end else if (tstate[2] & core_wait_n) begin
         di_reg <= di;
      end
   end

endmodule
